// File: rtl/regfile_port_arbiter.sv
// Two-client front end for a single-write/single-read-port register file.
// Clears every register after reset, then round-robins each port between c0 and c1.

module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    // ptr=0: c0 wins a tie, ptr=1: c1 wins a tie
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || !ptr)) gnt = 2'b01;
            else if (req[1])                 gnt = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        ptr <= 1'b0;
        else if (gnt[0]) ptr <= 1'b1;
        else if (gnt[1]) ptr <= 1'b0;
    end
endmodule

module regfile_port_arbiter #(
    parameter int            N        = 8,
    parameter int            R        = 32,
    parameter int            RR       = $clog2(R),
    parameter logic [N-1:0]  INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c0_wr_req,
    input  logic [RR-1:0] c0_wr_id,
    input  logic [N-1:0]  c0_wr_data,
    output logic          c0_wr_gnt,
    input  logic          c1_wr_req,
    input  logic [RR-1:0] c1_wr_id,
    input  logic [N-1:0]  c1_wr_data,
    output logic          c1_wr_gnt,
    input  logic          c0_rd_req,
    input  logic [RR-1:0] c0_rd_id,
    output logic          c0_rd_gnt,
    output logic          c0_rd_valid,
    output logic [N-1:0]  c0_rd_data,
    input  logic          c1_rd_req,
    input  logic [RR-1:0] c1_rd_id,
    output logic          c1_rd_gnt,
    output logic          c1_rd_valid,
    output logic [N-1:0]  c1_rd_data,
    output logic [N-1:0]  rf_data_in,
    output logic [RR-1:0] rf_reg_id_w,
    output logic          rf_wr,
    output logic [RR-1:0] rf_reg_id_r,
    input  logic [N-1:0]  rf_data_out,
    output logic          init_busy
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [RR-1:0] LAST_ID = RR'(R - 1);

    state_t        state;
    logic [1:0]    wr_gnt, rd_gnt, rd_pend;
    logic [RR-1:0] wr_id, rd_id;
    logic [N-1:0]  wr_data, rd_cap;
    logic          run;

    assign run = (state == S_RUN);

    rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .en(run), .req({c1_wr_req, c0_wr_req}), .gnt(wr_gnt));
    rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .en(run), .req({c1_rd_req, c0_rd_req}), .gnt(rd_gnt));

    assign c0_wr_gnt = wr_gnt[0];
    assign c1_wr_gnt = wr_gnt[1];
    assign c0_rd_gnt = rd_gnt[0];
    assign c1_rd_gnt = rd_gnt[1];

    assign wr_id   = wr_gnt[1] ? c1_wr_id   : c0_wr_id;
    assign wr_data = wr_gnt[1] ? c1_wr_data : c0_wr_data;
    assign rd_id   = rd_gnt[1] ? c1_rd_id   : c0_rd_id;

    // A write landing in the same cycle as the read sample wins over the stale array value
    assign rd_cap = (rf_wr && (rf_reg_id_w == rf_reg_id_r)) ? rf_data_in : rf_data_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_INIT;
            init_busy   <= 1'b1;
            rf_wr       <= 1'b0;
            rf_reg_id_w <= '0;
            rf_data_in  <= '0;
            rf_reg_id_r <= '0;
            rd_pend     <= 2'b00;
            c0_rd_valid <= 1'b0;
            c1_rd_valid <= 1'b0;
            c0_rd_data  <= '0;
            c1_rd_data  <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    // rf_reg_id_w doubles as the sweep counter; first cycle only raises rf_wr
                    rf_data_in <= INIT_VAL;
                    if (!rf_wr) begin
                        rf_wr <= 1'b1;
                    end else if (rf_reg_id_w == LAST_ID) begin
                        state     <= S_RUN;
                        init_busy <= 1'b0;
                        rf_wr     <= 1'b0;
                    end else begin
                        rf_reg_id_w <= rf_reg_id_w + 1'b1;
                    end
                end
                S_RUN: begin
                    rf_wr <= |wr_gnt;
                    if (|wr_gnt) begin
                        rf_reg_id_w <= wr_id;
                        rf_data_in  <= wr_data;
                    end
                    if (|rd_gnt) rf_reg_id_r <= rd_id;
                end
                default: state <= S_INIT;
            endcase

            rd_pend     <= rd_gnt;
            c0_rd_valid <= rd_pend[0];
            c1_rd_valid <= rd_pend[1];
            if (rd_pend[0]) c0_rd_data <= rd_cap;
            if (rd_pend[1]) c1_rd_data <= rd_cap;
        end
    end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: holds a register-file model and a
// transaction-level reference (reads see every write granted up to that cycle).

module tb_regfile_port_arbiter;
    localparam int N = 8;
    localparam int R = 32;
    localparam int RR = 5;
    localparam logic [N-1:0] INIT_VAL = 8'h00;

    logic          clk = 1'b0;
    logic          rst;
    logic          c0_wr_req, c1_wr_req, c0_rd_req, c1_rd_req;
    logic [RR-1:0] c0_wr_id, c1_wr_id, c0_rd_id, c1_rd_id;
    logic [N-1:0]  c0_wr_data, c1_wr_data;
    logic          c0_wr_gnt, c1_wr_gnt, c0_rd_gnt, c1_rd_gnt;
    logic          c0_rd_valid, c1_rd_valid;
    logic [N-1:0]  c0_rd_data, c1_rd_data;
    logic [N-1:0]  rf_data_in, rf_data_out;
    logic [RR-1:0] rf_reg_id_w, rf_reg_id_r;
    logic          rf_wr, init_busy;

    regfile_port_arbiter #(.N(N), .R(R), .RR(RR), .INIT_VAL(INIT_VAL)) dut (
        .clk(clk), .rst(rst),
        .c0_wr_req(c0_wr_req), .c0_wr_id(c0_wr_id), .c0_wr_data(c0_wr_data), .c0_wr_gnt(c0_wr_gnt),
        .c1_wr_req(c1_wr_req), .c1_wr_id(c1_wr_id), .c1_wr_data(c1_wr_data), .c1_wr_gnt(c1_wr_gnt),
        .c0_rd_req(c0_rd_req), .c0_rd_id(c0_rd_id), .c0_rd_gnt(c0_rd_gnt),
        .c0_rd_valid(c0_rd_valid), .c0_rd_data(c0_rd_data),
        .c1_rd_req(c1_rd_req), .c1_rd_id(c1_rd_id), .c1_rd_gnt(c1_rd_gnt),
        .c1_rd_valid(c1_rd_valid), .c1_rd_data(c1_rd_data),
        .rf_data_in(rf_data_in), .rf_reg_id_w(rf_reg_id_w), .rf_wr(rf_wr),
        .rf_reg_id_r(rf_reg_id_r), .rf_data_out(rf_data_out), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    // Register file being fronted; scramble fills it with junk so the sweep matters
    logic [N-1:0] rf_mem [R];
    bit scramble = 1'b0;
    assign rf_data_out = rf_mem[rf_reg_id_r];
    always @(posedge clk) begin
        if (scramble) for (int i = 0; i < R; i++) rf_mem[i] <= 8'($urandom_range(1, 255));
        else if (rf_wr) rf_mem[rf_reg_id_w] <= rf_data_in;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    typedef struct packed { logic v; logic c; logic [N-1:0] d; } rd_ev_t;
    logic [N-1:0] m_mem [R];
    bit           m_wprio, m_rprio;
    bit           e_wr, e_wr_n;
    logic [RR-1:0] e_wid, e_wid_n;
    logic [N-1:0]  e_wd, e_wd_n;
    rd_ev_t       g_now, g_m1, g_m2;
    logic [N-1:0] exp_hold [2];
    logic [1:0]   dwg, drg, mwg, mrg;

    function automatic logic [1:0] pick(input logic [1:0] req, input bit prio);
        if (req == 2'b11) return prio ? 2'b10 : 2'b01;
        return req;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < R; i++) m_mem[i] = INIT_VAL;
        m_wprio = 0; m_rprio = 0; e_wr_n = 0;
        g_now = '0; g_m1 = '0; g_m2 = '0;
        exp_hold[0] = '0; exp_hold[1] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        e_wr = e_wr_n; e_wid = e_wid_n; e_wd = e_wd_n;
        chk("rf_wr", rf_wr, e_wr);
        if (e_wr) begin
            chk("rf_reg_id_w", rf_reg_id_w, e_wid);
            chk("rf_data_in", rf_data_in, e_wd);
        end
        g_m2 = g_m1; g_m1 = g_now; g_now = '0;
        for (int c = 0; c < 2; c++) begin
            logic ev;
            ev = g_m2.v && (g_m2.c == 1'(c));
            if (ev) exp_hold[c] = g_m2.d;
            chk(c ? "c1_rd_valid" : "c0_rd_valid", c ? c1_rd_valid : c0_rd_valid, ev);
            chk(c ? "c1_rd_data" : "c0_rd_data", c ? c1_rd_data : c0_rd_data, exp_hold[c]);
        end
    endtask

    // Called at a falling edge: drive one cycle of requests, check grants, advance model
    task automatic run_cycle(input logic [1:0] wr, input logic [RR-1:0] wi0, input logic [N-1:0] wd0,
                             input logic [RR-1:0] wi1, input logic [N-1:0] wd1,
                             input logic [1:0] rd, input logic [RR-1:0] ri0, input logic [RR-1:0] ri1);
        c0_wr_req = wr[0]; c0_wr_id = wi0; c0_wr_data = wd0;
        c1_wr_req = wr[1]; c1_wr_id = wi1; c1_wr_data = wd1;
        c0_rd_req = rd[0]; c0_rd_id = ri0;
        c1_rd_req = rd[1]; c1_rd_id = ri1;
        #1;
        dwg = {c1_wr_gnt, c0_wr_gnt};
        drg = {c1_rd_gnt, c0_rd_gnt};
        mwg = pick(wr, m_wprio);
        mrg = pick(rd, m_rprio);
        chk("wr_gnt", dwg, mwg);
        chk("rd_gnt", drg, mrg);
        e_wr_n = |mwg;
        if (|mwg) begin
            e_wid_n = mwg[1] ? wi1 : wi0;
            e_wd_n  = mwg[1] ? wd1 : wd0;
            m_mem[e_wid_n] = e_wd_n;
            m_wprio = ~mwg[1];
        end
        if (|mrg) begin
            g_now = '{v: 1'b1, c: mrg[1], d: m_mem[mrg[1] ? ri1 : ri0]};
            m_rprio = ~mrg[1];
        end
        tick();
    endtask

    task automatic idle();
        run_cycle(2'b00, '0, '0, '0, '0, 2'b00, '0, '0);
    endtask

    task automatic set_reqs(input logic v);
        c0_wr_req = v; c1_wr_req = v; c0_rd_req = v; c1_rd_req = v;
        c0_wr_id = 5'd31; c1_wr_id = 5'd30; c0_rd_id = 5'd31; c1_rd_id = 5'd30;
        c0_wr_data = 8'hFF; c1_wr_data = 8'hEE;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rf_wr"}, rf_wr, 1'b0);
        chk({tag, "_id_w"}, rf_reg_id_w, 5'd0);
        chk({tag, "_data_in"}, rf_data_in, 8'h00);
        chk({tag, "_id_r"}, rf_reg_id_r, 5'd0);
        chk({tag, "_gnts"}, {c1_wr_gnt, c0_wr_gnt, c1_rd_gnt, c0_rd_gnt}, 4'h0);
        chk({tag, "_valids"}, {c1_rd_valid, c0_rd_valid}, 2'b00);
        chk({tag, "_rd_data"}, {c1_rd_data, c0_rd_data}, 16'h0000);
        chk({tag, "_busy"}, init_busy, 1'b1);
    endtask

    // Entered with rst low; releases it and follows the whole sweep (or aborts at abort_at)
    task automatic sweep(input int abort_at, input logic hold);
        @(negedge clk);
        reset_checks("rst");
        set_reqs(hold);
        rst = 1'b1;
        #1;
        chk("sweep0_gnts", {c1_wr_gnt, c0_wr_gnt, c1_rd_gnt, c0_rd_gnt}, 4'h0);
        chk("sweep0_rf_wr", rf_wr, 1'b0);
        for (int k = 1; k <= R; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("sweep_rf_wr", rf_wr, 1'b1);
            chk("sweep_id", rf_reg_id_w, 32'(k - 1));
            chk("sweep_data", rf_data_in, INIT_VAL);
            chk("sweep_busy", init_busy, 1'b1);
            chk("sweep_gnts", {c1_wr_gnt, c0_wr_gnt, c1_rd_gnt, c0_rd_gnt}, 4'h0);
            chk("sweep_valids", {c1_rd_valid, c0_rd_valid}, 2'b00);
            if (k - 1 == abort_at) begin
                rst = 1'b0;
                #1;
                reset_checks("abort");
                set_reqs(1'b0);
                return;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("run_busy", init_busy, 1'b0);
        chk("run_rf_wr", rf_wr, 1'b0);
        set_reqs(1'b0);
        model_reset();
    endtask

    typedef struct { logic [1:0] wr; logic [1:0] rd; logic [1:0] ewg; logic [1:0] erg; } vec_t;
    vec_t tbl [8];

    logic [1:0]    rq_w, rq_r;
    logic [RR-1:0] r_wi [2];
    logic [RR-1:0] r_ri [2];
    logic [N-1:0]  r_wd [2];
    int            idmax;

    initial begin
        // Bit 1 = c1, bit 0 = c0; both pointers start on c0 for row 0
        tbl[0] = '{2'b11, 2'b11, 2'b01, 2'b01};
        tbl[1] = '{2'b11, 2'b11, 2'b10, 2'b10};
        tbl[2] = '{2'b11, 2'b01, 2'b01, 2'b01};
        tbl[3] = '{2'b11, 2'b10, 2'b10, 2'b10};
        tbl[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        tbl[5] = '{2'b10, 2'b11, 2'b10, 2'b01};
        tbl[6] = '{2'b00, 2'b10, 2'b00, 2'b10};
        tbl[7] = '{2'b00, 2'b00, 2'b00, 2'b00};

        rst = 1'b0;
        set_reqs(1'b0);
        model_reset();
        scramble = 1'b1;
        @(posedge clk);
        #1 scramble = 1'b0;

        // Sweep after power-up with every request held high
        sweep(-1, 1'b1);

        // Competing writes from the first RUN cycle
        run_cycle(2'b11, 5'd3, 8'h11, 5'd4, 8'h22, 2'b00, '0, '0);
        chk("C_first_wgnt", dwg, 2'b01);
        run_cycle(2'b10, 5'd3, 8'h11, 5'd4, 8'h22, 2'b00, '0, '0);
        chk("C_second_wgnt", dwg, 2'b10);
        run_cycle(2'b00, '0, '0, '0, '0, 2'b11, 5'd3, 5'd4);
        chk("C_rd0_gnt", drg, 2'b01);
        run_cycle(2'b00, '0, '0, '0, '0, 2'b10, 5'd3, 5'd4);
        chk("C_rd1_gnt", drg, 2'b10);
        chk("C_c0_valid", c0_rd_valid, 1'b1);
        chk("C_c0_data", c0_rd_data, 8'h11);
        idle();
        chk("C_c1_valid", c1_rd_valid, 1'b1);
        chk("C_c1_data", c1_rd_data, 8'h22);
        chk("C_c0_hold", c0_rd_data, 8'h11);
        idle();

        for (int i = 0; i < 8; i++) begin
            run_cycle(tbl[i].wr, 5'd8, 8'h3C, 5'd9, 8'h4D, tbl[i].rd, 5'd9, 5'd8);
            chk($sformatf("tbl%0d_wgnt", i), dwg, tbl[i].ewg);
            chk($sformatf("tbl%0d_rgnt", i), drg, tbl[i].erg);
        end
        idle(); idle();

        // Top id write then read by the other client
        run_cycle(2'b01, 5'd31, 8'hA5, '0, '0, 2'b00, '0, '0);
        chk("B_wgnt", dwg, 2'b01);
        idle();
        run_cycle(2'b00, '0, '0, '0, '0, 2'b10, '0, 5'd31);
        chk("B_rgnt", drg, 2'b10);
        idle();
        chk("B_valid", c1_rd_valid, 1'b1);
        chk("B_data", c1_rd_data, 8'hA5);
        idle();

        // Same-cycle write and read of one id must return the new value
        run_cycle(2'b10, '0, '0, 5'd7, 8'h77, 2'b00, '0, '0);
        idle();
        run_cycle(2'b01, 5'd7, 8'h5C, '0, '0, 2'b10, '0, 5'd7);
        chk("D_gnts", {dwg, drg}, 4'b0110);
        idle();
        chk("D_valid", c1_rd_valid, 1'b1);
        chk("D_fwd_data", c1_rd_data, 8'h5C);
        idle();

        // Reset in the middle of the sweep, then a clean full sweep
        scramble = 1'b1;
        @(posedge clk);
        #1 scramble = 1'b0;
        rst = 1'b0;
        sweep(12, 1'b0);
        sweep(-1, 1'b0);

        // Randomized traffic with request hold-until-grant behaviour
        rq_w = 2'b00; rq_r = 2'b00;
        for (int n = 0; n < 800; n++) begin
            idmax = (n < 400) ? 3 : R - 1;
            for (int c = 0; c < 2; c++) begin
                if (!rq_w[c] || mwg[c]) begin
                    rq_w[c] = ($urandom_range(0, 99) < 55);
                    r_wi[c] = 5'($urandom_range(0, idmax));
                    r_wd[c] = 8'($urandom);
                end
                if (!rq_r[c] || mrg[c]) begin
                    rq_r[c] = ($urandom_range(0, 99) < 55);
                    r_ri[c] = 5'($urandom_range(0, idmax));
                end
            end
            run_cycle(rq_w, r_wi[0], r_wd[0], r_wi[1], r_wd[1], rq_r, r_ri[0], r_ri[1]);
        end
        idle(); idle();

        // Reset right after a read grant: the pulse must never appear
        run_cycle(2'b00, '0, '0, '0, '0, 2'b01, 5'd5, '0);
        chk("F_rgnt", drg, 2'b01);
        rst = 1'b0;
        #1;
        reset_checks("F");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("F_no_valid", c0_rd_valid, 1'b0);
        end
        sweep(-1, 1'b0);
        for (int k = 0; k < 4; k++) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Controller in front of the NxR register file: shares its single write port and single read port between two client ports (c0, c1).
- Round-robin arbitration with a valid/grant handshake on each port.
- After every reset, sequences an initialisation sweep that writes INIT_VAL to all R registers before any client is granted.
- Sits between client logic and regfileNxR. It drives that module's data_in, reg_id_w, reg_id_r and wr, and samples its data_out.

Parameters:
- N, 8, data width (bits per register)
- R, 32, number of registers
- RR, $clog2(R), register-id width
- INIT_VAL, 0, value written to every register during the init sweep

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- c0_wr_req  in  1  client 0 write request
- c0_wr_id  in  RR  client 0 write register id
- c0_wr_data  in  N  client 0 write data
- c0_wr_gnt  out  1  client 0 write accepted this cycle
- c1_wr_req / c1_wr_id / c1_wr_data / c1_wr_gnt  same as c0
- c0_rd_req  in  1  client 0 read request
- c0_rd_id  in  RR  client 0 read register id
- c0_rd_gnt  out  1  client 0 read accepted this cycle
- c0_rd_valid  out  1  client 0 read data valid pulse
- c0_rd_data  out  N  client 0 read data
- c1_rd_req / c1_rd_id / c1_rd_gnt / c1_rd_valid / c1_rd_data  same as c0
- rf_data_in  out  N  to regfile data_in
- rf_reg_id_w  out  RR  to regfile reg_id_w
- rf_wr  out  1  to regfile wr
- rf_reg_id_r  out  RR  to regfile reg_id_r
- rf_data_out  in  N  from regfile data_out (combinational read of reg_id_r)
- init_busy  out  1  high while init sweep runs

Behaviour:
- Reset (rst low, async): all registered outputs 0; c*_rd_data=0; both round-robin pointers point to c0; FSM enters INIT with sweep counter=0; init_busy=1.
- FSM INIT:
  - each cycle: rf_wr=1, rf_reg_id_w=counter, rf_data_in=INIT_VAL; counter increments.
  - After the cycle with counter=R-1, the FSM moves to RUN. Exactly R write cycles; the counter must not wrap.
  - init_busy falls in the first RUN cycle.
  - No grants are issued in INIT; requests are ignored, not queued.
- FSM RUN: stays in RUN until reset.
- Write arbitration (RUN only):
  - c*_wr_gnt is combinational from req and pointer; at most one grant per cycle.
  - Only one requesting: grant it. Both requesting: grant the client the pointer selects.
  - After any grant, the pointer moves to the other client.
  - A client holds req/id/data stable until it sees gnt. A gnt-high cycle means the transfer is accepted.
- Write latency:
  - A grant in cycle t registers rf_wr=1, rf_reg_id_w and rf_data_in for cycle t+1. The regfile writes at the end of t+1.
  - rf_wr=0 in any cycle following a no-grant cycle.
- Read arbitration: an independent round-robin pointer, same rules as write arbitration.
- Read latency:
  - A grant in cycle t registers rf_reg_id_r for cycle t+1; rf_data_out is sampled at the end of t+1.
  - c*_rd_valid pulses for exactly one cycle in t+2, with c*_rd_data, for the granted client only.
  - c*_rd_data holds its last value when not valid.
  - Back-to-back grants give back-to-back valids.
- Write/read forwarding: if cycle t+1 has rf_wr=1 and rf_reg_id_w==rf_reg_id_r, the captured read data is rf_data_in (new value), not rf_data_out.
- Ids are used unmodified. The top id R-1 must be fully accessible; id arithmetic exists only in the sweep counter.
- Reset mid-operation:
  - In-flight writes are dropped; pending rd_valid pulses are cancelled.
  - After rst returns high, the sweep restarts from id 0.
- rf_reg_id_r holds its last value when idle.

Test Plan:
- Reset release -> rf_wr=1 for exactly 32 consecutive cycles, ids 0..31, data 0x00; init_busy low from cycle 33; no gnt during the sweep even with both reqs held high.
- RUN; c0 writes 0xA5 to id 31; two cycles later c1 reads id 31 -> c1_rd_gnt same cycle, c1_rd_valid 2 cycles later with data 0xA5.
- c0 and c1 both write (id 3=0x11, id 4=0x22) from the first RUN cycle -> c0 granted cycle t, c1 at t+1; later reads return 0x11 and 0x22; all req held for 4 cycles -> grants alternate c0,c1,c0,c1.
- c0 writes 0x5C to id 7 while c1 reads id 7 in the same cycle -> c1_rd_data=0x5C (forwarded), not the old value.
- rst pulsed low at sweep id 12 -> outputs clear immediately; after release the sweep restarts at id 0 and runs a full 32 cycles.
- c0 read granted, rst asserted in the next cycle -> no c0_rd_valid pulse is ever produced.
